uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8-bit UART transmitter between NREQ byte requesters.
- Grants one requester, latches its byte, pulses the transmitter's start input, and waits for its done tick.
- Inserts an optional inter-frame gap, then re-arbitrates.
- Sits between the system-side producers (command responders, debug/status sources) and the UART transmit datapath.

---
 rtl/uart_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter and sequencer that shares one 8-bit UART transmitter
//   between NREQ byte requesters. It grants one requester, latches its byte,
//   pulses tx_start, waits for tx_done_tick, optionally idles for GAP_TICKS
//   s_tick ticks, and then arbitrates again. An optional watchdog abandons a
//   frame whose done tick never arrives.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   req[NREQ]     per-requester request
//   data[8*NREQ]  byte of requester i at data[8*i+7:8*i]
//   ack[NREQ]     one-cycle pulse: requester's byte latched
//   done[NREQ]    one-cycle pulse: requester's byte fully transmitted
//   timeout       one-cycle pulse: watchdog expired, byte abandoned
//   busy          high in every state except IDLE
//   s_tick        baud oversampling tick (only counted in GAP)
//   tx_start      start pulse to the transmitter, one per granted byte
//   tx_data       byte to the transmitter, held until the frame ends
//   tx_done_tick  transmitter end-of-frame pulse (only honoured in WAIT)
//   state_dbg     current FSM state (IDLE=0, START=1, WAIT=2, GAP=3)
//
// Handshake: a requester raises req[i] with data[i] stable and keeps both
// until it sees ack[i]. ack[i] is the "accepted" strobe: the byte has been
// latched, and req/data may change from the following cycle. Keeping req[i]
// high after ack[i] counts as a fresh request with the new byte. Requests are
// only sampled while the FSM sits in IDLE.
module uart_tx_arbiter #(
   parameter int NREQ        = 4,
   parameter int GAP_TICKS   = 0,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] data,
   output logic [NREQ-1:0]   ack,
   output logic [NREQ-1:0]   done,
   output logic              timeout,
   output logic              busy,
   input  logic              s_tick,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              tx_done_tick,
   output logic [1:0]        state_dbg
);

   localparam int PW = $clog2(NREQ);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   logic [1:0]    state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] gnt;
   logic [19:0]   wd_cnt;
   logic [7:0]    gap_cnt;

   logic [PW-1:0] pick;
   logic          pick_vld;
   logic [PW:0]   rot_sum;
   logic [PW-1:0] rot_idx;
   logic [PW-1:0] ptr_next;

   assign state_dbg = state;

   // Rotating priority search. Offsets are scanned from the farthest to the
   // nearest so that the nearest asserted index (ptr, ptr+1, ...) is the last
   // one written and therefore wins.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      rot_sum  = '0;
      rot_idx  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         rot_sum = {1'b0, ptr} + (PW+1)'(k);
         if (rot_sum >= (PW+1)'(NREQ))
            rot_sum = rot_sum - (PW+1)'(NREQ);
         rot_idx = rot_sum[PW-1:0];
         if (req[rot_idx]) begin
            pick     = rot_idx;
            pick_vld = 1'b1;
         end
      end
   end

   // Pointer always moves one past the last granted index, whether the
   // frame completed or was abandoned by the watchdog.
   always_comb begin
      if (gnt == PW'(NREQ - 1))
         ptr_next = '0;
      else
         ptr_next = gnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         ptr      <= '0;
         gnt      <= '0;
         ack      <= '0;
         done     <= '0;
         timeout  <= 1'b0;
         busy     <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= '0;
         wd_cnt   <= '0;
         gap_cnt  <= '0;
      end else begin
         // Pulse outputs default low; each is raised for exactly one cycle.
         ack      <= '0;
         done     <= '0;
         timeout  <= 1'b0;
         tx_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  state    <= S_START;
                  gnt      <= pick;
                  tx_data  <= data[{pick, 3'b000} +: 8];
                  ack      <= NREQ'(1) << pick;
                  tx_start <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_START: begin
               state  <= S_WAIT;
               wd_cnt <= '0;
            end
            S_WAIT: begin
               // A done tick on the expiry cycle takes priority over timeout.
               if (tx_done_tick) begin
                  done    <= NREQ'(1) << gnt;
                  ptr     <= ptr_next;
                  gap_cnt <= '0;
                  if (GAP_TICKS > 0) begin
                     state <= S_GAP;
                     busy  <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else if ((TIMEOUT_CYC > 0) && (wd_cnt == 20'(TIMEOUT_CYC - 1))) begin
                  timeout <= 1'b1;
                  ptr     <= ptr_next;
                  state   <= S_IDLE;
                  busy    <= 1'b0;
               end else begin
                  wd_cnt <= wd_cnt + 20'd1;
               end
            end
            S_GAP: begin
               if (s_tick) begin
                  if (gap_cnt == 8'(GAP_TICKS - 1)) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     gap_cnt <= gap_cnt + 8'd1;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter. Two instances share the clock
//   and reset: dut_a (no gap, no watchdog) and dut_b (16-tick gap, 100-cycle
//   watchdog). The sel signal routes stimulus to one instance and selects
//   which instance's outputs are observed. A round-robin reference model
//   (rotating search from a tracked pointer) predicts each grant, and the
//   transmitter is modelled by driving tx_done_tick after a chosen delay.
module tb_uart_tx_arbiter;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd3;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] data;
   logic        s_tick;
   logic        tx_done_tick;
   logic        sel;

   logic [3:0] ack_a, done_a, ack_b, done_b;
   logic       to_a, busy_a, start_a, to_b, busy_b, start_b;
   logic [7:0] txd_a, txd_b;
   logic [1:0] st_a, st_b;

   logic [3:0] o_ack, o_done;
   logic       o_to, o_busy, o_start;
   logic [7:0] o_txd;
   logic [1:0] o_st;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;
   int ptr_m[2];
   int last_g;
   logic [7:0] last_byte;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(4), .GAP_TICKS(0), .TIMEOUT_CYC(0)) dut_a (
      .clk(clk), .reset(reset), .req(req & {4{~sel}}), .data(data),
      .ack(ack_a), .done(done_a), .timeout(to_a), .busy(busy_a),
      .s_tick(s_tick & ~sel), .tx_start(start_a), .tx_data(txd_a),
      .tx_done_tick(tx_done_tick & ~sel), .state_dbg(st_a));

   uart_tx_arbiter #(.NREQ(4), .GAP_TICKS(16), .TIMEOUT_CYC(100)) dut_b (
      .clk(clk), .reset(reset), .req(req & {4{sel}}), .data(data),
      .ack(ack_b), .done(done_b), .timeout(to_b), .busy(busy_b),
      .s_tick(s_tick & sel), .tx_start(start_b), .tx_data(txd_b),
      .tx_done_tick(tx_done_tick & sel), .state_dbg(st_b));

   assign o_ack   = sel ? ack_b   : ack_a;
   assign o_done  = sel ? done_b  : done_a;
   assign o_to    = sel ? to_b    : to_a;
   assign o_busy  = sel ? busy_b  : busy_a;
   assign o_start = sel ? start_b : start_a;
   assign o_txd   = sel ? txd_b   : txd_a;
   assign o_st    = sel ? st_b    : st_a;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference arbitration: first asserted index in ptr, ptr+1, ... mod 4.
   function automatic int rr_pick(input int p, input logic [3:0] r);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   // Called at a negedge with req already driven and the DUT in IDLE.
   task automatic expect_grant(input string tag);
      int g;
      logic [3:0] oh;
      g = rr_pick(ptr_m[sel], req);
      oh = 4'b0001 << g;
      last_byte = data[8*g +: 8];
      @(negedge clk);
      chk({tag, " tx_start"}, 32'(o_start), 32'd1);
      chk({tag, " ack"},      32'(o_ack),   32'(oh));
      chk({tag, " tx_data"},  32'(o_txd),   32'(last_byte));
      chk({tag, " busy"},     32'(o_busy),  32'd1);
      chk({tag, " state"},    32'(o_st),    32'(ST_START));
      chk({tag, " no_done"},  32'(o_done),  32'd0);
      chk({tag, " no_to"},    32'(o_to),    32'd0);
      last_g = g;
   endtask

   // Transmitter model: tx_done_tick is driven on the len-th negedge after
   // the START cycle's negedge (len >= 2 so it lands in WAIT).
   task automatic run_frame(input string tag, input int len, input bit tick_all);
      logic bad;
      logic [3:0] oh;
      bad = 1'b0;
      oh = 4'b0001 << last_g;
      for (int i = 0; i < len; i++) begin
         s_tick = tick_all ? 1'b1 : 1'($urandom_range(0, 1));
         tx_done_tick = (i == len - 1);
         @(negedge clk);
         if (i < len - 1 && (o_ack != 4'd0 || o_start || o_done != 4'd0 || o_to)) bad = 1'b1;
      end
      tx_done_tick = 1'b0;
      s_tick = 1'b0;
      chk({tag, " quiet_wait"}, 32'(bad),    32'd0);
      chk({tag, " done"},       32'(o_done), 32'(oh));
      chk({tag, " no_to"},      32'(o_to),   32'd0);
      chk({tag, " held_data"},  32'(o_txd),  32'(last_byte));
      chk({tag, " busy"},       32'(o_busy), sel ? 32'd1 : 32'd0);
      chk({tag, " state"},      32'(o_st),   sel ? 32'(ST_GAP) : 32'(ST_IDLE));
      ptr_m[sel] = (last_g + 1) % 4;
   endtask

   // Counts 16 s_ticks, one every 'every' cycles, starting at the done negedge.
   task automatic gap_phase(input string tag, input int every);
      int cnt;
      int ti;
      logic bad;
      cnt = 0;
      ti = 0;
      bad = 1'b0;
      while (cnt < 16) begin
         s_tick = ((ti % every) == 0);
         if (s_tick) cnt++;
         if (s_tick && cnt == 16)
            chk({tag, " still_gap"}, 32'(o_st), 32'(ST_GAP));
         @(negedge clk);
         ti++;
         if (o_start || o_ack != 4'd0) bad = 1'b1;
      end
      s_tick = 1'b0;
      chk({tag, " no_grant"}, 32'(bad),    32'd0);
      chk({tag, " idle"},     32'(o_st),   32'(ST_IDLE));
      chk({tag, " busy"},     32'(o_busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL sim_time_limit observed=expired expected=finish");
      $fatal(1);
   end

   initial begin
      logic bad;
      reset = 1'b0;
      req = 4'd0;
      data = 32'd0;
      s_tick = 1'b0;
      tx_done_tick = 1'b0;
      sel = 1'b0;
      ptr_m[0] = 0;
      ptr_m[1] = 0;
      last_g = 0;
      last_byte = 8'd0;
      repeat (3) @(negedge clk);

      // Reset state of both instances.
      chk("rst a busy",  32'(busy_a),  32'd0);
      chk("rst a ack",   32'(ack_a),   32'd0);
      chk("rst a done",  32'(done_a),  32'd0);
      chk("rst a start", 32'(start_a), 32'd0);
      chk("rst a txd",   32'(txd_a),   32'd0);
      chk("rst a state", 32'(st_a),    32'(ST_IDLE));
      chk("rst b to",    32'(to_b),    32'd0);
      chk("rst b busy",  32'(busy_b),  32'd0);
      chk("rst b txd",   32'(txd_b),   32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("idle no req", 32'(o_start), 32'd0);

      // Round robin with all four requesting continuously.
      req = 4'b1111;
      data = 32'h13121110;
      for (int n = 0; n < 5; n++) begin
         expect_grant("rr");
         chk("rr order", 32'(last_g), 32'(n % 4));
         if (n == 4) req = 4'd0;
         run_frame("rr", $urandom_range(2, 30), 1'b0);
      end

      // Single request, 160 s_ticks of frame.
      req = 4'b0001;
      data[7:0] = 8'hA5;
      expect_grant("single");
      req = 4'd0;
      run_frame("single", 160, 1'b1);
      @(negedge clk);
      chk("single done_1cyc", 32'(o_done), 32'd0);

      // Fairness: move ptr to 2, then 0 and 2 compete.
      req = 4'b0010;
      expect_grant("fair1");
      req = 4'b0000;
      run_frame("fair1", 4, 1'b0);
      req = 4'b0101;
      data = 32'(32'h00_66_00_55);
      expect_grant("fair2");
      chk("fair2 idx", 32'(last_g), 32'd2);
      req = 4'b0001;
      run_frame("fair2", 6, 1'b0);
      expect_grant("fair3");
      chk("fair3 idx", 32'(last_g), 32'd0);
      data[7:0] = 8'h77;
      run_frame("fair3", 3, 1'b0);
      expect_grant("fair4");
      chk("fair4 idx", 32'(last_g), 32'd0);
      req = 4'd0;
      run_frame("fair4", 3, 1'b0);

      // Randomized traffic on the no-gap instance.
      for (int i = 0; i < 4; i++) data[8*i +: 8] = 8'($urandom_range(0, 255));
      req = 4'($urandom_range(1, 15));
      for (int n = 0; n < 20; n++) begin
         expect_grant("rand");
         data[8*last_g +: 8] = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 0) req[last_g] = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (!req[i]) begin
               data[8*i +: 8] = 8'($urandom_range(0, 255));
               req[i] = 1'($urandom_range(0, 1));
            end
         end
         if (req == 4'd0) req[$urandom_range(0, 3)] = 1'b1;
         run_frame("rand", $urandom_range(2, 40), 1'b0);
      end
      req = 4'd0;
      @(negedge clk);

      // Reset in the middle of WAIT.
      req = 4'b0100;
      expect_grant("rstw");
      req = 4'd0;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rstw busy",  32'(o_busy),  32'd0);
      chk("rstw ack",   32'(o_ack),   32'd0);
      chk("rstw start", 32'(o_start), 32'd0);
      chk("rstw txd",   32'(o_txd),   32'd0);
      chk("rstw state", 32'(o_st),    32'(ST_IDLE));
      @(negedge clk);
      tx_done_tick = 1'b1;
      @(negedge clk);
      tx_done_tick = 1'b0;
      chk("rstw no_done", 32'(o_done), 32'd0);
      chk("rstw no_to",   32'(o_to),   32'd0);
      @(negedge clk);
      reset = 1'b1;
      ptr_m[0] = 0;
      ptr_m[1] = 0;
      req = 4'b0010;
      expect_grant("rstw regrant");
      chk("rstw idx", 32'(last_g), 32'd1);
      req = 4'd0;
      run_frame("rstw", 5, 1'b0);

      // Gap instance: two queued requests separated by 16 s_ticks.
      sel = 1'b1;
      @(negedge clk);
      req = 4'b0011;
      data[15:0] = 16'hBB_AA;
      expect_grant("gap1");
      req = 4'b0010;
      run_frame("gap1", 10, 1'b1);
      gap_phase("gap1", 3);
      expect_grant("gap2");
      chk("gap2 idx", 32'(last_g), 32'd1);
      req = 4'd0;
      run_frame("gap2", 8, 1'b0);
      gap_phase("gap2", 1);

      // Watchdog: done withheld, timeout 101 negedges after the START negedge.
      req = 4'b0100;
      expect_grant("wd");
      req = 4'd0;
      bad = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         s_tick = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (o_to || o_done != 4'd0) bad = 1'b1;
      end
      s_tick = 1'b0;
      @(negedge clk);
      chk("wd early",   32'(bad),    32'd0);
      chk("wd timeout", 32'(o_to),   32'd1);
      chk("wd no_done", 32'(o_done), 32'd0);
      chk("wd busy",    32'(o_busy), 32'd0);
      ptr_m[1] = (last_g + 1) % 4;
      req = 4'b1001;
      expect_grant("wd next");
      chk("wd next idx", 32'(last_g), 32'd3);
      req = 4'd0;
      // Done tick lands on the expiry cycle: done wins.
      run_frame("wd tie", 101, 1'b0);
      gap_phase("wd tie", 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
